pipeline_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core. Sits beside the decode-stage control unit.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/load_use_detect.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline sequencer and the decode-stage control unit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

endpackage : pipe_ctrl_pkg

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the instruction in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             lu_haz
);

    logic w_dst_live;
    logic w_rs_hit;
    logic w_rt_hit;

    // $zero is never a real dependency
    assign w_dst_live = (idex_rt != REG_W'(REG_ZERO));
    assign w_rs_hit   = (idex_rt == id_rs);
    assign w_rt_hit   = id_uses_rt & (idex_rt == id_rt);
    assign lu_haz     = idex_memread & w_dst_live & (w_rs_hit | w_rt_hit);

endmodule : load_use_detect

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, branch/jump flushes, memory-wait freeze and timeout trap.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_mem_timeout;
    logic              w_lu_haz;
    logic              w_mem_busy;
    logic              w_freeze;
    logic              w_limit;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .lu_haz       (w_lu_haz)
    );

    assign w_mem_busy = mem_access & ~dmem_ready;

    // r_wait_cnt counts completed frozen cycles, so the current MEM_WAIT cycle is number r_wait_cnt+1
    assign w_limit = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    assign w_freeze = ((r_state == ST_RUN) & w_mem_busy)
                    | ((r_state == ST_MEM_WAIT) & ~dmem_ready)
                    | (r_state == ST_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mem_busy) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (w_limit) begin
                    w_state_nxt = ST_TRAP;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            ST_TRAP: begin
                w_state_nxt = ST_TRAP;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // Priority mux: freeze, taken branch, load-use, jump, normal advance
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (!rst_n) begin
            pc_write = 1'b1;
        end else if (w_freeze) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_lu_haz) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_timeout <= 1'b0;
        end else if (w_state_nxt == ST_TRAP) begin
            r_mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!pc_write && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign stall_count = r_stall_cnt;

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard/freeze/timeout cases plus random traffic.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 4;
    localparam int          STALL_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             id_jump;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt;
    logic             ex_branch_taken;
    logic             mem_access;
    logic             dmem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    typedef struct {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_freeze;
        logic mem_timeout;
        int   stall;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: consecutive frozen cycles, trap latch, stall total
    bit   m_trapped;
    int   m_frozen;
    int   m_stall;

    pipeline_hazard_ctrl #(
        .REG_W       (REG_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .idex_memread    (idex_memread),
        .idex_rt         (idex_rt),
        .ex_branch_taken (ex_branch_taken),
        .mem_access      (mem_access),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .pipe_freeze     (pipe_freeze),
        .mem_timeout     (mem_timeout),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    task automatic drive(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                         input logic uses_rt, input logic jump, input logic memrd,
                         input logic [REG_W-1:0] exrt, input logic br,
                         input logic macc, input logic rdy);
        exp_t e;
        bit   lu;
        bit   frz;
        @(posedge clk);
        #1;
        rst_n           = 1'b1;
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rt      = uses_rt;
        id_jump         = jump;
        idex_memread    = memrd;
        idex_rt         = exrt;
        ex_branch_taken = br;
        mem_access      = macc;
        dmem_ready      = rdy;

        lu  = memrd && (exrt != 0) && ((exrt == rs) || (uses_rt && (exrt == rt)));
        frz = m_trapped || ((m_frozen > 0) ? !rdy : (macc && !rdy));

        e.pc_write    = 1'b1;
        e.ifid_write  = 1'b1;
        e.ifid_flush  = 1'b0;
        e.idex_bubble = 1'b0;
        e.pipe_freeze = frz;
        e.mem_timeout = m_trapped;
        e.stall       = m_stall;
        if (frz) begin
            e.pc_write   = 1'b0;
            e.ifid_write = 1'b0;
        end else if (br) begin
            e.ifid_flush  = 1'b1;
            e.idex_bubble = 1'b1;
        end else if (lu) begin
            e.pc_write    = 1'b0;
            e.ifid_write  = 1'b0;
            e.idex_bubble = 1'b1;
        end else if (jump) begin
            e.ifid_flush = 1'b1;
        end
        q.push_back(e);

        if (!e.pc_write && m_stall < STALL_MAX) m_stall++;
        if (!m_trapped) begin
            if (frz) begin
                m_frozen++;
                if (m_frozen == int'(MEM_TIMEOUT)) m_trapped = 1'b1;
            end else begin
                m_frozen = 0;
            end
        end
    endtask

    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = 1'b0;
        id_rs           = REG_W'($urandom);
        id_rt           = REG_W'($urandom);
        id_uses_rt      = 1'($urandom);
        id_jump         = 1'($urandom);
        idex_memread    = 1'($urandom);
        idex_rt         = REG_W'($urandom);
        ex_branch_taken = 1'($urandom);
        mem_access      = 1'($urandom);
        dmem_ready      = 1'($urandom);
        m_trapped = 1'b0;
        m_frozen  = 0;
        m_stall   = 0;
        e.pc_write    = 1'b1;
        e.ifid_write  = 1'b1;
        e.ifid_flush  = 1'b0;
        e.idex_bubble = 1'b0;
        e.pipe_freeze = 1'b0;
        e.mem_timeout = 1'b0;
        e.stall       = 0;
        q.push_back(e);
    endtask

    task automatic rand_cycle();
        drive(REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
              1'($urandom), ($urandom_range(0, 99) < 15),
              ($urandom_range(0, 99) < 50), REG_W'($urandom_range(0, 3)),
              ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 40),
              ($urandom_range(0, 99) < 65));
    endtask

    // Monitor: outputs are combinational, so every cycle with a pending expectation is compared
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_write",    int'(pc_write),    int'(e.pc_write));
            chk("ifid_write",  int'(ifid_write),  int'(e.ifid_write));
            chk("ifid_flush",  int'(ifid_flush),  int'(e.ifid_flush));
            chk("idex_bubble", int'(idex_bubble), int'(e.idex_bubble));
            chk("pipe_freeze", int'(pipe_freeze), int'(e.pipe_freeze));
            chk("mem_timeout", int'(mem_timeout), int'(e.mem_timeout));
            chk("stall_count", int'(stall_count), e.stall);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        id_rs           = '0;
        id_rt           = '0;
        id_uses_rt      = 1'b0;
        id_jump         = 1'b0;
        idex_memread    = 1'b0;
        idex_rt         = '0;
        ex_branch_taken = 1'b0;
        mem_access      = 1'b0;
        dmem_ready      = 1'b1;
        m_trapped       = 1'b0;
        m_frozen        = 0;
        m_stall         = 0;

        do_reset();
        do_reset();

        // load-use on rs, then the load moves to MEM; idex_rt=0 never stalls
        drive(8, 3, 0, 0, 1, 8, 0, 0, 1);
        drive(8, 3, 0, 0, 0, 8, 0, 0, 1);
        drive(0, 0, 1, 0, 1, 0, 0, 0, 1);
        drive(5, 8, 1, 0, 1, 8, 0, 0, 1);
        drive(5, 8, 0, 0, 1, 8, 0, 0, 1);

        // branch beats load-use; load-use beats jump; plain jump
        drive(8, 3, 0, 0, 1, 8, 1, 0, 1);
        drive(8, 2, 0, 1, 1, 8, 0, 0, 1);
        drive(1, 2, 0, 1, 0, 0, 0, 0, 1);

        // three-cycle memory wait, branch held across it flushes on release
        drive(1, 2, 0, 0, 0, 0, 1, 1, 0);
        drive(1, 2, 0, 0, 0, 0, 1, 1, 0);
        drive(1, 2, 0, 0, 0, 0, 1, 1, 0);
        drive(1, 2, 0, 0, 0, 0, 1, 1, 1);
        drive(1, 2, 0, 0, 0, 0, 0, 0, 1);

        // timeout: four frozen cycles then trap, sticky even when memory answers
        repeat (4) drive(3, 3, 1, 0, 1, 3, 0, 1, 0);
        repeat (3) drive(1, 2, 0, 1, 0, 0, 1, 0, 1);
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // ready on the limit cycle wins
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // reset mid-wait
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

        // stall counter saturation
        do_reset();
        repeat (20) drive(8, 0, 0, 0, 1, 8, 0, 0, 1);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

        repeat (500) begin
            if ($urandom_range(0, 39) == 0 || (m_trapped && $urandom_range(0, 3) == 0))
                do_reset();
            else
                rand_cycle();
        end

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
